// File: rtl/image_resize_bicubic_htap.sv
// image_resize_bicubic_htap
//   Horizontal tap/weight generator for the bicubic resizer. One source line
//   of 24-bit RGB pixels is buffered, then every destination pixel produces
//   four neighbouring source pixels plus four Q2.8 signed cubic weights
//   (a = -0.5, 16 phases, each row sums to 256).
//
// Ports
//   clk, reset                  clock, async active-high reset
//   src_width_i/dst_width_i     line lengths, latched on first pixel of a line
//   step_i                      Q8.8 source pixels per destination pixel
//   in_valid_i/in_data_i        source pixel stream, in_ready_o handshake
//   valid_o                     taps/weights valid, one destination pixel/cycle
//   data0_o..data3_o            source pixels at i-1, i, i+1, i+2 (clamped)
//   weight0_o..weight3_o        signed weights for data0..data3
//   line_done_o                 one-cycle pulse with the final destination pixel

// One tap lane: private copy of the line buffer, clamped read address,
// read register and output register.
module image_resize_bicubic_htap_lane #(
    parameter int MAX_WIDTH = 1024,
    parameter int OFFSET    = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         we,
    input  logic [$clog2(MAX_WIDTH)-1:0] waddr,
    input  logic [23:0]                  wdata,
    input  logic                         issue,
    input  logic [18:0]                  base_idx,
    input  logic [10:0]                  src_width,
    input  logic                         load,
    output logic [23:0]                  data_o
);
    localparam int AW = $clog2(MAX_WIDTH);
    localparam logic signed [20:0] OFF = 21'(OFFSET);

    logic [23:0]        mem [MAX_WIDTH];
    logic signed [20:0] tap;
    logic [AW-1:0]      addr_c;
    logic [AW-1:0]      addr_q;
    logic [23:0]        rd_q;

    // Full-width signed index so i-1 at i=0 and i+2 past the end both clamp.
    assign tap = $signed({2'b00, base_idx}) + OFF;

    always_comb begin
        addr_c = tap[AW-1:0];
        if (tap[20])
            addr_c = '0;
        else if (tap >= $signed({10'd0, src_width}))
            addr_c = AW'(src_width - 11'd1);
    end

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        rd_q <= mem[addr_q];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
            data_o <= '0;
        end else begin
            if (issue)
                addr_q <= addr_c;
            if (load)
                data_o <= rd_q;
        end
    end
endmodule

module image_resize_bicubic_htap #(
    parameter int MAX_WIDTH = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] src_width_i,
    input  logic [10:0] dst_width_i,
    input  logic [15:0] step_i,
    input  logic        in_valid_i,
    input  logic [23:0] in_data_i,
    output logic        in_ready_o,
    output logic        valid_o,
    output logic [23:0] data0_o,
    output logic [23:0] data1_o,
    output logic [23:0] data2_o,
    output logic [23:0] data3_o,
    output logic [9:0]  weight0_o,
    output logic [9:0]  weight1_o,
    output logic [9:0]  weight2_o,
    output logic [9:0]  weight3_o,
    output logic        line_done_o
);
    localparam int AW       = $clog2(MAX_WIDTH);
    localparam int NUM_TAPS = 4;
    localparam int STAGES   = 2;

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [10:0]   src_width_q, dst_width_q, wr_cnt_q, out_cnt_q;
    logic [15:0]   step_q;
    logic [26:0]   pos_q;
    logic          in_ready_q;
    logic [STAGES:0] vld_pipe, done_pipe;
    logic [3:0]    phase_q;
    logic [NUM_TAPS-1:0][9:0]  w_rd_q, w_out_q;
    logic [NUM_TAPS-1:0][23:0] tap_data;
    logic          xfer, issue, last;
    logic [AW-1:0] wr_addr;
    logic [3:0]    pos_unused;

    assign xfer       = in_valid_i & in_ready_q;
    assign issue      = (state_q == DRAIN) && (out_cnt_q != dst_width_q);
    assign last       = issue && (out_cnt_q == dst_width_q - 11'd1);
    assign wr_addr    = (state_q == IDLE) ? '0 : wr_cnt_q[AW-1:0];
    assign pos_unused = pos_q[3:0];

    function automatic logic [NUM_TAPS-1:0][9:0] row(input int w0, input int w1,
                                                     input int w2, input int w3);
        row = {10'(w3), 10'(w2), 10'(w1), 10'(w0)};
    endfunction

    // Rows: round(256*W(1+t)), remainder, round(256*W(1-t)), round(256*W(2-t)).
    function automatic logic [NUM_TAPS-1:0][9:0] wrom(input logic [3:0] p);
        case (p)
            4'd0:    wrom = row(  0, 256,   0,   0);
            4'd1:    wrom = row( -7, 253,  10,   0);
            4'd2:    wrom = row(-12, 247,  23,  -2);
            4'd3:    wrom = row(-16, 237,  39,  -4);
            4'd4:    wrom = row(-18, 222,  58,  -6);
            4'd5:    wrom = row(-19, 206,  78,  -9);
            4'd6:    wrom = row(-19, 186, 100, -11);
            4'd7:    wrom = row(-18, 166, 122, -14);
            4'd8:    wrom = row(-16, 144, 144, -16);
            4'd9:    wrom = row(-14, 122, 166, -18);
            4'd10:   wrom = row(-11, 100, 186, -19);
            4'd11:   wrom = row( -9,  79, 205, -19);
            4'd12:   wrom = row( -6,  58, 222, -18);
            4'd13:   wrom = row( -4,  40, 236, -16);
            4'd14:   wrom = row( -2,  23, 247, -12);
            default: wrom = row(  0,   9, 254,  -7);
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (xfer) state_d = (src_width_i <= 11'd1) ? DRAIN : FILL;
            FILL:    if (xfer && (wr_cnt_q + 11'd1 == src_width_q)) state_d = DRAIN;
            DRAIN:   if (dst_width_q == 11'd0 || last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            src_width_q <= '0;
            dst_width_q <= '0;
            step_q      <= '0;
            wr_cnt_q    <= '0;
            out_cnt_q   <= '0;
            pos_q       <= '0;
            vld_pipe    <= '0;
            done_pipe   <= '0;
            phase_q     <= '0;
            w_rd_q      <= '0;
            w_out_q     <= '0;
        end else begin
            state_q    <= state_d;
            // Ready drops with DRAIN entry and returns once the last read is issued.
            in_ready_q <= (state_d != DRAIN);

            if (state_q == IDLE && xfer) begin
                src_width_q <= src_width_i;
                dst_width_q <= dst_width_i;
                step_q      <= step_i;
                wr_cnt_q    <= 11'd1;
            end else if (state_q == FILL && xfer) begin
                wr_cnt_q <= wr_cnt_q + 11'd1;
            end

            if (state_d == DRAIN && state_q != DRAIN) begin
                pos_q     <= '0;
                out_cnt_q <= '0;
            end else if (issue) begin
                pos_q     <= pos_q + {11'd0, step_q};
                out_cnt_q <= out_cnt_q + 11'd1;
            end

            if (issue)
                phase_q <= pos_q[7:4];
            w_rd_q <= wrom(phase_q);
            if (vld_pipe[STAGES-1])
                w_out_q <= w_rd_q;

            vld_pipe <= {vld_pipe[STAGES-1:0], issue};
            // An empty destination line has no pixels to carry the done flag,
            // so it is injected one stage late to pulse 2 cycles after DRAIN entry.
            done_pipe <= {done_pipe[1],
                          done_pipe[0] | (state_q == DRAIN && dst_width_q == 11'd0),
                          last};
        end
    end

    for (genvar l = 0; l < NUM_TAPS; l++) begin : g_lane
        image_resize_bicubic_htap_lane #(
            .MAX_WIDTH (MAX_WIDTH),
            .OFFSET    (l - 1)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .we        (xfer),
            .waddr     (wr_addr),
            .wdata     (in_data_i),
            .issue     (issue),
            .base_idx  (pos_q[26:8]),
            .src_width (src_width_q),
            .load      (vld_pipe[STAGES-1]),
            .data_o    (tap_data[l])
        );
    end

    assign in_ready_o  = in_ready_q;
    assign valid_o     = vld_pipe[STAGES];
    assign line_done_o = done_pipe[STAGES];
    assign data0_o     = tap_data[0];
    assign data1_o     = tap_data[1];
    assign data2_o     = tap_data[2];
    assign data3_o     = tap_data[3];
    assign weight0_o   = w_out_q[0];
    assign weight1_o   = w_out_q[1];
    assign weight2_o   = w_out_q[2];
    assign weight3_o   = w_out_q[3];
endmodule

// File: tb/tb_image_resize_bicubic_htap.sv
// Scoreboard bench for image_resize_bicubic_htap: the driver pushes expected
// outputs (with their expected cycle) computed from the cubic kernel, a
// negedge monitor pops and compares every valid_o / line_done_o cycle.
module tb_image_resize_bicubic_htap;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] src_width_i = '0;
    logic [10:0] dst_width_i = '0;
    logic [15:0] step_i = '0;
    logic        in_valid_i = 1'b0;
    logic [23:0] in_data_i = '0;
    logic        in_ready_o, valid_o, line_done_o;
    logic [23:0] data0_o, data1_o, data2_o, data3_o;
    logic [9:0]  weight0_o, weight1_o, weight2_o, weight3_o;

    image_resize_bicubic_htap dut (
        .clk(clk), .reset(reset),
        .src_width_i(src_width_i), .dst_width_i(dst_width_i), .step_i(step_i),
        .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
        .valid_o(valid_o),
        .data0_o(data0_o), .data1_o(data1_o), .data2_o(data2_o), .data3_o(data3_o),
        .weight0_o(weight0_o), .weight1_o(weight1_o), .weight2_o(weight2_o),
        .weight3_o(weight3_o), .line_done_o(line_done_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    typedef struct {
        logic [3:0][23:0] d;
        logic [3:0][9:0]  w;
        bit               vld;
        bit               done;
        int               cyc;
        int               k;
    } exp_t;

    exp_t sb[$];

    function automatic real kern(input real x);
        real a;
        a = (x < 0.0) ? -x : x;
        if (a <= 1.0)      return 1.5*a*a*a - 2.5*a*a + 1.0;
        else if (a < 2.0)  return -0.5*a*a*a + 2.5*a*a - 4.0*a + 2.0;
        else               return 0.0;
    endfunction

    function automatic int rnd(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    endfunction

    // Monitor
    initial forever begin
        exp_t e;
        bit   ok;
        @(negedge clk);
        if (!reset && (valid_o || line_done_o)) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output cyc %0d valid %b done %b", cyc, valid_o, line_done_o);
            end else begin
                e  = sb.pop_front();
                ok = (e.vld == valid_o) && (e.done == line_done_o) && (e.cyc == cyc);
                if (e.vld)
                    ok = ok && data0_o === e.d[0] && data1_o === e.d[1] &&
                         data2_o === e.d[2] && data3_o === e.d[3] &&
                         weight0_o === e.w[0] && weight1_o === e.w[1] &&
                         weight2_o === e.w[2] && weight3_o === e.w[3];
                if (!ok) begin
                    errors++;
                    $display("FAIL out k=%0d got cyc %0d v%b d%b taps %h %h %h %h w %0d %0d %0d %0d | exp cyc %0d v%b d%b taps %h %h %h %h w %0d %0d %0d %0d",
                        e.k, cyc, valid_o, line_done_o, data0_o, data1_o, data2_o, data3_o,
                        $signed(weight0_o), $signed(weight1_o), $signed(weight2_o), $signed(weight3_o),
                        e.cyc, e.vld, e.done, e.d[0], e.d[1], e.d[2], e.d[3],
                        $signed(e.w[0]), $signed(e.w[1]), $signed(e.w[2]), $signed(e.w[3]));
                end
            end
        end
    end

    // Feed one source line; call and return on a negedge. abort_at > 0 stops
    // after that many accepted pixels without expecting any output.
    task automatic run_line(input int src, input int dst, input int step,
                            input bit ident, input bit hold, input int abort_at);
        logic [23:0] px[$];
        int n, guard, c_last, d_cyc, pos, i, p, j, w0, w2, w3;
        real t;
        bit bad;
        exp_t e;
        n = 0; guard = 0; c_last = 0;
        for (int q = 0; q < src; q++)
            px.push_back(ident ? 24'(32'h010101 * q) : 24'($urandom()));
        while (n < src && guard < 2000 && !(abort_at > 0 && n == abort_at)) begin
            if (n == 0) begin
                src_width_i = 11'(src); dst_width_i = 11'(dst); step_i = 16'(step);
            end else begin
                // Config must only be latched with the first pixel.
                src_width_i = 11'($urandom()); dst_width_i = 11'($urandom()); step_i = 16'($urandom());
            end
            in_valid_i = hold || ($urandom_range(3) != 0);
            in_data_i  = px[n];
            if (in_valid_i && in_ready_o) begin
                n++;
                c_last = cyc;
            end
            @(negedge clk);
            guard++;
        end
        in_valid_i = hold;
        in_data_i  = 24'($urandom());
        if (abort_at > 0 && n == abort_at) return;
        if (n < src) begin
            checks++; errors++;
            $display("FAIL fill_timeout accepted %0d need %0d", n, src);
            in_valid_i = 1'b0;
            return;
        end
        if (dst == 0) begin
            e.d = '0; e.w = '0; e.vld = 0; e.done = 1; e.cyc = c_last + 3; e.k = -1;
            sb.push_back(e);
        end
        for (int k = 0; k < dst; k++) begin
            pos = k * step;
            i   = pos / 256;
            p   = (pos / 16) % 16;
            t   = p / 16.0;
            for (int m = 0; m < 4; m++) begin
                j = i - 1 + m;
                if (j < 0) j = 0;
                if (j > src - 1) j = src - 1;
                e.d[m] = px[j];
            end
            w0 = rnd(256.0 * kern(1.0 + t));
            w2 = rnd(256.0 * kern(1.0 - t));
            w3 = rnd(256.0 * kern(2.0 - t));
            e.w[0] = 10'(w0);
            e.w[1] = 10'(256 - w0 - w2 - w3);
            e.w[2] = 10'(w2);
            e.w[3] = 10'(w3);
            e.vld  = 1;
            e.done = (k == dst - 1);
            e.cyc  = c_last + 4 + k;
            e.k    = k;
            sb.push_back(e);
        end
        // Ready low for the whole drain, back high right after.
        d_cyc = (dst == 0) ? 1 : dst;
        bad = 0;
        for (int q = 0; q < d_cyc; q++) begin
            if (in_ready_o !== 1'b0) bad = 1;
            src_width_i = 11'($urandom()); dst_width_i = 11'($urandom()); step_i = 16'($urandom());
            @(negedge clk);
        end
        checks++;
        if (bad || in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL drain_ready low_violation %b final %b expected final 1", bad, in_ready_o);
        end
    endtask

    task automatic drain_wait();
        for (int g = 0; g < 200 && sb.size() != 0; g++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_wait pending %0d expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (valid_o !== 0 || line_done_o !== 0 || in_ready_o !== 0 ||
            {data0_o, data1_o, data2_o, data3_o} !== '0 ||
            {weight0_o, weight1_o, weight2_o, weight3_o} !== '0) begin
            errors++;
            $display("FAIL %s v%b d%b r%b taps %h %h %h %h w %h %h %h %h expected all 0",
                name, valid_o, line_done_o, in_ready_o, data0_o, data1_o, data2_o, data3_o,
                weight0_o, weight1_o, weight2_o, weight3_o);
        end
    endtask

    task automatic check_ready(input string name, input logic expv);
        checks++;
        if (in_ready_o !== expv) begin
            errors++;
            $display("FAIL %s in_ready got %b expected %b", name, in_ready_o, expv);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_zero("reset_state");
        reset = 1'b0;
        check_ready("ready_after_release", 1'b0);
        @(negedge clk);
        check_ready("ready_rise", 1'b1);

        run_line(8, 8, 16'h0100, 1, 0, 0);    // identity
        run_line(4, 8, 16'h0080, 0, 0, 0);    // 2x upscale
        run_line(8, 4, 16'h0200, 0, 0, 0);    // downscale
        run_line(6, 9, $urandom_range(32, 700), 0, 1, 0);  // back-to-back, valid held
        run_line(5, 3, $urandom_range(32, 700), 0, 1, 0);
        in_valid_i = 1'b0;
        drain_wait();

        // Reset mid-fill
        run_line(8, 8, 16'h0100, 0, 0, 3);
        in_valid_i = 1'b0;
        reset = 1'b1;
        #1;
        check_zero("reset_midfill");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_ready("ready_after_midfill_release", 1'b0);
        @(negedge clk);
        check_ready("ready_rise_midfill", 1'b1);
        run_line(8, 8, 16'h0100, 1, 0, 0);

        run_line(1, 5, $urandom_range(32, 700), 0, 0, 0);  // src = 1
        run_line(4, 0, 16'h0100, 0, 0, 0);                 // dst = 0
        for (int r = 0; r < 8; r++)
            run_line($urandom_range(1, 40), $urandom_range(0, 40),
                     $urandom_range(0, 1024), 0, $urandom_range(1), 0);
        in_valid_i = 1'b0;
        drain_wait();
        repeat (10) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
